inst_fetch_unit: RTL

Instruction fetch stage of the nux core. Holds the fetch PC, issues sequential reads to the instruction memory, buffers returned words with their addresses in a 2-entry queue, and presents `inst`/`pc`/`npc` plus `valid` to decode. At the core top level these outputs connect to the `inst_fetch` modport of `Decode_data_if`. Honours decode back-pressure (`stall`) and branch redirects (`jump`).

---
 rtl/inst_fetch_unit_pkg.sv | 20 ++
 rtl/inst_fetch_unit_fetch_queue.sv | 72 +++++++
 rtl/inst_fetch_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared types for the nux fetch stage: instruction/address words,
// the fetch-queue entry layout and the default reset PC.
package inst_fetch_unit_pkg;

    typedef logic [31:0] Inst;
    typedef logic [31:0] Address;

    localparam Address INST_FETCH_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        Inst    inst;
        Address pc;
    } fetch_entry_t;

    // Sequential word address; wraps from 32'hFFFF_FFFC to 0.
    function automatic Address next_word(input Address a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Small synchronous FIFO of {inst, pc} entries between the memory response
// and decode. Flush wins over push and pop.
module fetch_queue
    import inst_fetch_unit_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2,
    localparam int OCC_W = $clog2(QUEUE_DEPTH + 1),
    localparam int PTR_W = $clog2(QUEUE_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output logic [OCC_W-1:0] occ,
    output fetch_entry_t     head
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);

    fetch_entry_t     mem_q [QUEUE_DEPTH];
    fetch_entry_t     mem_d [QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the fetch PC and issue logic, feeds the fetch queue from
// a one-cycle-latency instruction memory and presents the head to decode.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter Address RESET_PC    = INST_FETCH_RESET_PC,
    parameter int     QUEUE_DEPTH = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   stall,
    input  logic   jump,
    input  Address jump_target,
    output logic   imem_en,
    output Address imem_addr,
    input  Inst    imem_data,
    output Inst    inst,
    output Address pc,
    output Address npc,
    output logic   valid
);

    localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [OCC_W:0] DEPTH_L = (OCC_W + 1)'(QUEUE_DEPTH);

    // Decode handshake: an instruction transfers in any cycle where valid is
    // high, stall is low and no jump is redirecting; otherwise the head holds.
    logic             pop;
    logic             push;
    logic             jump_live;
    logic             room;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   level;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    Address fpc_q, fpc_d;
    Address req_addr_q, req_addr_d;
    logic   inflight_q, inflight_d;

    fetch_queue #(
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .flush     (jump),
        .occ       (occ),
        .head      (head)
    );

    always_comb begin
        jump_live  = jump & reset;
        valid      = (occ != '0);
        pop        = valid & ~stall & ~jump;
        // A response landing in the jump cycle belongs to the old path.
        push       = inflight_q & ~jump;
        push_entry = '{inst: imem_data, pc: req_addr_q};
        level      = {1'b0, occ} + (OCC_W + 1)'(inflight_q) - (OCC_W + 1)'(pop);
        room       = (level < DEPTH_L);
        imem_en    = reset & (jump | room);
        imem_addr  = jump_live ? (jump_target & ~32'h3) : fpc_q;
        fpc_d      = imem_en ? next_word(imem_addr) : fpc_q;
        req_addr_d = imem_en ? imem_addr : req_addr_q;
        inflight_d = imem_en;
        inst       = valid ? head.inst : '0;
        pc         = valid ? head.pc : '0;
        npc        = valid ? next_word(head.pc) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q      <= RESET_PC;
            req_addr_q <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            req_addr_q <= req_addr_d;
            inflight_q <= inflight_d;
        end
    end

endmodule
